// File: rtl/reservoir_pkg.sv
// reservoir_pkg: FSM state type, node-index width helper and saturating fixed-point helpers.
// Helpers operate on 64-bit operands and 128-bit products, so data words up to 64 bits are supported.
package reservoir_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, PROCESS = 1'b1} state_t;
  localparam int WW = 64;
  function automatic int node_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  // Negation that maps the most-negative dw-bit value to the most-positive one.
  function automatic logic signed [WW-1:0] neg_sat(input logic signed [WW-1:0] v, input int dw);
    logic signed [WW-1:0] w_min;
    w_min = -(64'sd1 <<< (dw - 1));
    return (v == w_min) ? ~w_min : -v;
  endfunction
  function automatic logic signed [2*WW-1:0] mul_shift(input logic signed [WW-1:0] a,
                                                       input logic signed [WW-1:0] b,
                                                       input int frac);
    logic signed [2*WW-1:0] w_p;
    w_p = (2*WW)'(a) * (2*WW)'(b);
    return w_p >>> frac;
  endfunction
  function automatic logic signed [2*WW-1:0] clamp(input logic signed [2*WW-1:0] s,
                                                   input logic signed [2*WW-1:0] lim);
    return (s > lim) ? lim : ((s < -lim) ? -lim : s);
  endfunction
endpackage

// File: rtl/reservoir_node_mac.sv
// reservoir_node_mac: combinational mask, multiply-shift, sum and clamp for one virtual node.
// RESERVOIR_COUPLING_EN adds the shifted previous node value to the sum before the clamp.
module reservoir_node_mac
  import reservoir_pkg::*;
#(
  parameter int     DATA_WIDTH   = 32,
  parameter int     FRAC_BITS    = 16,
  parameter int     COUPLE_SHIFT = 1,
  parameter longint CLIP         = 64'sd1 <<< FRAC_BITS
) (
  input  logic                         i_pos,
  input  logic signed [DATA_WIDTH-1:0] i_u,
  input  logic signed [DATA_WIDTH-1:0] i_in_gain,
  input  logic signed [DATA_WIDTH-1:0] i_fb_gain,
  input  logic signed [DATA_WIDTH-1:0] i_line,
  input  logic signed [DATA_WIDTH-1:0] i_xprev,
  output logic signed [DATA_WIDTH-1:0] o_x
);
  logic signed [DATA_WIDTH-1:0] w_m, w_tin, w_tfb, w_tc;
  logic signed [DATA_WIDTH+1:0] w_s;
  logic signed [2*WW-1:0]       w_c;
  assign w_m   = i_pos ? i_u : DATA_WIDTH'(neg_sat(WW'(i_u), DATA_WIDTH));
  assign w_tin = DATA_WIDTH'(mul_shift(WW'(w_m), WW'(i_in_gain), FRAC_BITS));
  assign w_tfb = DATA_WIDTH'(mul_shift(WW'(i_line), WW'(i_fb_gain), FRAC_BITS));
`ifdef RESERVOIR_COUPLING_EN
  assign w_tc = i_xprev >>> COUPLE_SHIFT;
`else
  logic w_unused;
  assign w_unused = ^{i_xprev, COUPLE_SHIFT[0]};
  assign w_tc = '0;
`endif
  assign w_s = (DATA_WIDTH+2)'(w_tin) + (DATA_WIDTH+2)'(w_tfb) + (DATA_WIDTH+2)'(w_tc);
  assign w_c = clamp((2*WW)'(w_s), (2*WW)'(CLIP));
  assign o_x = DATA_WIDTH'(w_c);
endmodule

// File: rtl/reservoir_stream.sv
// reservoir_stream: delay-feedback reservoir, one virtual node per cycle, with handshake and node stream.
// Optional neighbour coupling is enabled by defining RESERVOIR_COUPLING_EN.
module reservoir_stream
  import reservoir_pkg::*;
#(
  parameter int                       VIRTUAL_NODES = 10,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       FRAC_BITS     = 16,
  parameter logic [VIRTUAL_NODES-1:0] MASK          = 10'b1010101010,
  parameter longint                   CLIP          = 64'sd1 <<< FRAC_BITS,
  parameter int                       COUPLE_SHIFT  = 1,
  localparam int                      IW            = node_idx_w(VIRTUAL_NODES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic signed [DATA_WIDTH-1:0] in_gain,
  input  logic signed [DATA_WIDTH-1:0] fb_gain,
  input  logic                         clear,
  output logic                         dout_valid,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic [IW-1:0]                dout_node,
  output logic                         sample_done
);
  localparam logic [IW-1:0] LAST = IW'(VIRTUAL_NODES - 1);
  state_t                       r_state;
  logic [IW-1:0]                r_idx, r_dout_node;
  logic signed [DATA_WIDTH-1:0] r_u, r_ig, r_fg, r_xprev, r_dout;
  logic signed [DATA_WIDTH-1:0] r_line [VIRTUAL_NODES];
  logic                         r_dout_valid, r_done;
  logic signed [DATA_WIDTH-1:0] w_x, w_xprev;
  logic                         w_last, w_accept, w_proc;
  assign w_proc      = r_state == PROCESS;
  assign w_last      = r_idx == LAST;
  assign din_ready   = w_proc ? w_last : !clear;
  assign w_accept    = din_valid & din_ready;
  // Node 0 couples to the last entry written, which closes the ring across samples.
  assign w_xprev     = (r_idx == '0) ? r_line[VIRTUAL_NODES-1] : r_xprev;
  assign dout_valid  = r_dout_valid;
  assign dout        = r_dout;
  assign dout_node   = r_dout_node;
  assign sample_done = r_done;
  reservoir_node_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .COUPLE_SHIFT(COUPLE_SHIFT),
    .CLIP        (CLIP)
  ) u_mac (
    .i_pos    (MASK[r_idx]),
    .i_u      (r_u),
    .i_in_gain(r_ig),
    .i_fb_gain(r_fg),
    .i_line   (r_line[r_idx]),
    .i_xprev  (w_xprev),
    .o_x      (w_x)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_u          <= '0;
      r_ig         <= '0;
      r_fg         <= '0;
      r_xprev      <= '0;
      r_dout       <= '0;
      r_dout_node  <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < VIRTUAL_NODES; i++) r_line[i] <= '0;
    end else begin
      r_dout_valid <= w_proc;
      r_done       <= w_proc && w_last;
      r_state      <= (w_accept || (w_proc && !w_last)) ? PROCESS : IDLE;
      if (w_proc) begin
        r_line[r_idx] <= w_x;
        r_dout        <= w_x;
        r_dout_node   <= r_idx;
        r_xprev       <= w_x;
        r_idx         <= w_last ? '0 : r_idx + 1'b1;
      end
      if (!w_proc && clear)
        for (int i = 0; i < VIRTUAL_NODES; i++) r_line[i] <= '0;
      if (w_accept) begin
        r_u  <= din;
        r_ig <= in_gain;
        r_fg <= fb_gain;
      end
    end
  end
endmodule

// File: tb/tb_reservoir_stream.sv
// tb_reservoir_stream: randomized scoreboard bench with a behavioural reservoir model.
module tb_reservoir_stream;
  localparam int N = 10;
  localparam longint CL = 64'sd1 <<< 16;
  logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0, clear = 1'b0;
  logic signed [31:0] din = '0, in_gain = '0, fb_gain = '0;
  logic din_ready, dout_valid, sample_done;
  logic signed [31:0] dout;
  logic [3:0] dout_node;
  typedef struct {int node; longint val; bit done;} exp_t;
  exp_t q[$];
  longint line[N];
  logic [N-1:0] mask = 10'b1010101010;
  logic [31:0] last_out[N];
  int total = 0, bad = 0, dones = 0;

  reservoir_stream dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .in_gain(in_gain), .fb_gain(fb_gain), .clear(clear), .dout_valid(dout_valid),
    .dout(dout), .dout_node(dout_node), .sample_done(sample_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic longint wrap32(input longint v);
    return longint'(int'(v));
  endfunction

  // Reference: apply the node rules to the whole sample at accept time.
  function automatic void model(input longint u, input longint ig, input longint fg);
    longint xp, m, s, x;
    xp = line[N-1];
    for (int k = 0; k < N; k++) begin
      m = mask[k] ? u : ((u == -64'sd2147483648) ? 64'sd2147483647 : -u);
      s = wrap32((m * ig) >>> 16) + wrap32((line[k] * fg) >>> 16);
`ifdef RESERVOIR_COUPLING_EN
      s = s + (xp >>> 1);
`endif
      x = (s > CL) ? CL : ((s < -CL) ? -CL : s);
      line[k] = x;
      xp = x;
      q.push_back('{k, x, k == N - 1});
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) line[k] = 0;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (sample_done && !dout_valid) chk("done_without_valid", 1, 0);
      if (dout_valid) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("dout_node", longint'(dout_node), e.node);
          chk("dout", longint'(dout), e.val);
          chk("sample_done", longint'(sample_done), longint'(e.done));
        end
        last_out[dout_node] = dout;
        if (sample_done) dones++;
      end
    end
  end

  task automatic send(input longint u, input longint ig, input longint fg, output int cyc);
    bit rdy, ok;
    ok = 0;
    cyc = 0;
    @(negedge clk);
    din = u[31:0]; in_gain = ig[31:0]; fb_gain = fg[31:0]; din_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (i != 0) @(negedge clk);
      #1 rdy = din_ready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        model(u, ig, fg);
        ok = 1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_left", q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c, d0;
    bit found;
    longint u, ig, fg;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_node", dout_node, 0);
    chk("rst_sample_done", sample_done, 0);
    rst = 1'b1;
    #1 chk("idle_ready", din_ready, 1);

    send(64'h10000, 64'h8000, 0, c);
    idle(1);
    drain();
    chk("basic_node0", last_out[0], 32'hFFFF_8000);
`ifdef RESERVOIR_COUPLING_EN
    chk("basic_node1", last_out[1], 32'h0000_4000);
`else
    chk("basic_node1", last_out[1], 32'h0000_8000);
    chk("basic_node9", last_out[9], 32'h0000_8000);
`endif
    chk("basic_dones", dones, 1);

    send(0, 0, 64'h8000, c);
    idle(1);
    drain();
`ifndef RESERVOIR_COUPLING_EN
    chk("fb_node0", last_out[0], 32'hFFFF_C000);
    chk("fb_node1", last_out[1], 32'h0000_4000);
`endif

    send(64'h100000, 64'h10000, 0, c);
    idle(1);
    drain();
`ifndef RESERVOIR_COUPLING_EN
    chk("clip_node0", last_out[0], 32'hFFFF_0000);
    chk("clip_node1", last_out[1], 32'h0001_0000);
`endif
    send(-64'sd2147483648, 64'h10000, 0, c);
    idle(1);
    drain();
`ifndef RESERVOIR_COUPLING_EN
    chk("minneg_node0", last_out[0], 32'h0001_0000);
    chk("minneg_node1", last_out[1], 32'hFFFF_0000);
`endif

    d0 = dones;
    send(64'h18000, 64'h10000, 64'h4000, c);
    send(-64'sd40000, 64'h8000, 64'h8000, c);
    chk("b2b_gap2", c, N);
    send(64'h9000, -64'sd30000, 64'hC000, c);
    chk("b2b_gap3", c, N);
    idle(1);
    drain();
    chk("b2b_dones", dones - d0, 3);

    @(negedge clk);
    clear = 1'b1;
    #1 chk("clear_blocks_ready", din_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    send(0, 64'h10000, 64'h10000, c);
    idle(1);
    drain();
    chk("after_clear_node5", last_out[5], 0);

    send(64'h10000, 64'h10000, 0, c);
    idle(1);
    drain();
    @(negedge clk);
    clear = 1'b1; din_valid = 1'b1; din = 32'h10000; in_gain = 32'h10000;
    #1 chk("clear_valid_ready", din_ready, 0);
    @(negedge clk);
    clear = 1'b0; din_valid = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("clear_valid_no_out", dout_valid, 0);

    for (int n = 0; n < 25; n++) begin
      u  = longint'($urandom_range(0, 32'h80000)) - 64'h40000;
      ig = longint'($urandom_range(0, 32'h40000)) - 64'h20000;
      fg = longint'($urandom_range(0, 32'h30000)) - 64'h18000;
      send(u, ig, fg, c);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(1);
    drain();

    d0 = dones;
    found = 0;
    send(64'h10000, 64'h8000, 64'h8000, c);
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #2 if (dout_valid && dout_node == 4'd4) found = 1;
      else @(negedge clk);
    end
    chk("reach_node4", found, 1);
    rst = 1'b0;
    #1 chk("midrst_valid", dout_valid, 0);
    chk("midrst_done", sample_done, 0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", dones - d0, 0);
    send(0, 64'h10000, 64'h10000, c);
    idle(1);
    drain();
    chk("midrst_zero_fb_node4", last_out[4], 0);
    chk("midrst_zero_fb_node0", last_out[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
